comparador_ctrl: RTL and testbench
==================================

COMPARADOR_CTRL -- requirements
Module: comparador_ctrl

Interface
REQ-001 SHALL provide parameter MATCH_COUNT, default 3, meaning consecutive equal samples required for a hit (legal range 1..15).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port cfg_load  input  1  capture cfg_const into constant register.
REQ-005 SHALL provide port cfg_const  input  4  comparison constant, bit 3 = MSB.
REQ-006 SHALL provide port start  input  1  begin a detection run.
REQ-007 SHALL provide port abort  input  1  terminate any run, return to idle.
REQ-008 SHALL provide port in_valid  input  1  in_data holds a sample.
REQ-009 SHALL provide port in_data  input  4  sample {a,b,c,d}, bit 3 = a.
REQ-010 SHALL provide port in_ready  output  1  block accepts a sample this cycle.
REQ-011 SHALL provide port eq  output  1  registered equality result of the last accepted sample.
REQ-012 SHALL provide port hit  output  1  one-cycle pulse, MATCH_COUNT consecutive matches seen.
REQ-013 SHALL provide port hit_total  output  8  number of hits since reset or start.
REQ-014 SHALL provide port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, HIT; state register and all outputs registered.
REQ-016 Equality SHALL be 1 iff all four bits of in_data equal constant register (bitwise XNOR, AND-reduced).
REQ-017 IDLE: in_ready=0; cfg_load=1 loads cfg_const into constant register on the edge; cfg_load outside IDLE SHALL be ignored.
REQ-018 IDLE: start=1 -> RUN next cycle; run counter cleared to 0; hit_total cleared to 0.
REQ-019 RUN: in_ready=1; a transfer occurs on a cycle with in_valid=1 and in_ready=1; no transfer otherwise, and counters hold.
REQ-020 RUN transfer with match: run counter increments; eq=1 next cycle.
REQ-021 RUN transfer with mismatch: run counter clears to 0; eq=0 next cycle; state stays RUN.
REQ-022 RUN transfer completing MATCH_COUNT consecutive matches -> HIT next cycle; run counter clears to 0 (non-overlapping detection).
REQ-023 HIT: lasts exactly one cycle; hit=1; in_ready=0; hit_total increments, saturating at 255; then -> RUN.
REQ-024 hit SHALL be 0 in every state other than HIT.
REQ-025 Latency: hit asserts exactly one cycle after the edge accepting the completing sample.
REQ-026 start while in RUN or HIT SHALL be ignored.
REQ-027 abort=1 in any state -> IDLE next cycle; run counter cleared; hit_total and eq retained; abort takes priority over start, transfer and HIT exit.
REQ-028 Samples presented while in_ready=0 SHALL not be consumed and SHALL not affect counters or eq.
REQ-029 With MATCH_COUNT=1 every matching transfer SHALL produce a HIT cycle.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, constant register 4'b0000, run counter 0, eq=0, hit=0, hit_total=0, in_ready=0, busy=0, independent of clk.
REQ-031 Reset asserted mid-run SHALL discard the partial run; first run after release requires start.
REQ-032 Operation resumes on the first rising clk edge after rst_n deasserts.

Verification
REQ-033 Reset, cfg_load with 4'b0101, start, samples 5,5,5 consecutively -> hit=1 one cycle after third transfer, hit_total=1, in_ready=0 during HIT.
REQ-034 Constant 4'b0101, samples 5,5,4,5,5,5 -> no hit after the 4, single hit after the final 5, eq sequence 1,1,0,1,1,1.
REQ-035 Constant 4'b0101, samples 5,5 then in_valid=0 for 3 cycles then 5 -> hit after the final 5 (gaps do not break the run).
REQ-036 Mid-run (two matches counted) assert abort together with start -> IDLE, busy=0; new start then 5,5,5 required for next hit.
REQ-037 Drive 256 hits with MATCH_COUNT=1 -> hit_total saturates at 255; cfg_load during RUN with 4'b1111 -> constant stays 4'b0101.
REQ-038 Assert rst_n=0 mid-run without clock edge -> all outputs at reset values immediately.

Source files
------------

// File: rtl/comparador_if.sv
// Sample, configuration and status bundle for the consecutive-match detector.
interface comparador_if;
  logic       cfg_load;
  logic [3:0] cfg_const;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       eq;
  logic       hit;
  logic [7:0] hit_total;
  logic       busy;

  modport master (
    output cfg_load, cfg_const, start, abort, in_valid, in_data,
    input  in_ready, eq, hit, hit_total, busy
  );

  modport slave (
    input  cfg_load, cfg_const, start, abort, in_valid, in_data,
    output in_ready, eq, hit, hit_total, busy
  );
endinterface

// File: rtl/comparador_ctrl.sv
// Counts consecutive samples equal to a loaded 4-bit constant and pulses hit
// after MATCH_COUNT of them; hit_total tallies hits per run, saturating at 255.
module comparador_ctrl #(
  parameter int unsigned MATCH_COUNT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  comparador_if.slave   bus
);

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned TW = 8;
  localparam logic [CW-1:0] LAST_MATCH = CW'(MATCH_COUNT - 1);
  localparam logic [TW-1:0] TOTAL_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   const_q, const_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   total_q, total_d;
  logic            eq_q, eq_d;
  logic            hit_q, hit_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;

  logic            match_c;
  logic            transfer_c;

  assign match_c    = &(~(bus.in_data ^ const_q));
  assign transfer_c = bus.in_valid & in_ready_q;

  // Next-state, counters and registered output values
  always_comb begin
    state_d = state_q;
    const_d = const_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    eq_d    = eq_q;

    if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cfg_load) const_d = bus.cfg_const;
          if (bus.start) begin
            state_d = RUN;
            cnt_d   = '0;
            total_d = '0;
          end
        end
        RUN: begin
          if (transfer_c) begin
            eq_d = match_c;
            if (!match_c) begin
              cnt_d = '0;
            end else if (cnt_q == LAST_MATCH) begin
              // Non-overlapping: the next hit needs a fresh streak
              state_d = HIT;
              cnt_d   = '0;
              if (total_q != TOTAL_MAX) total_d = total_q + TW'(1);
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        HIT:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end

    in_ready_d = (state_d == RUN);
    busy_d     = (state_d != IDLE);
    hit_d      = (state_d == HIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      const_q    <= '0;
      cnt_q      <= '0;
      total_q    <= '0;
      eq_q       <= 1'b0;
      hit_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      const_q    <= const_d;
      cnt_q      <= cnt_d;
      total_q    <= total_d;
      eq_q       <= eq_d;
      hit_q      <= hit_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.eq        = eq_q;
  assign bus.hit       = hit_q;
  assign bus.hit_total = total_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_comparador_ctrl.sv
// Scoreboard bench: two detectors (MATCH_COUNT 3 and 1) share stimulus and are
// checked every cycle against a run/streak reference model.
module tb_comparador_ctrl;

  logic clk;
  logic rst_n;

  comparador_if u_if3 ();
  comparador_if u_if1 ();

  comparador_ctrl #(.MATCH_COUNT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(u_if3.slave));
  comparador_ctrl #(.MATCH_COUNT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // Expected {in_ready, eq, hit, busy, hit_total}
  logic [11:0] exp_q3[$];
  logic [11:0] exp_q1[$];

  // Reference model: is a run active, is this the hit cycle, current streak
  int          mc       [2] = '{3, 1};
  bit          m_active [2];
  bit          m_hitcyc [2];
  int          m_streak [2];
  logic [3:0]  m_const  [2];
  int          m_total  [2];
  bit          m_eq     [2];

  function automatic logic [11:0] obs(input int k);
    if (k == 0) return {u_if3.in_ready, u_if3.eq, u_if3.hit, u_if3.busy, u_if3.hit_total};
    return {u_if1.in_ready, u_if1.eq, u_if1.hit, u_if1.busy, u_if1.hit_total};
  endfunction

  function automatic logic [11:0] model_out(input int k);
    logic [7:0] t;
    t = 8'(m_total[k]);
    return {m_active[k] && !m_hitcyc[k], m_eq[k], m_hitcyc[k], m_active[k], t};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 0; m_hitcyc[k] = 0; m_streak[k] = 0;
      m_const[k] = 4'h0; m_total[k] = 0; m_eq[k] = 0;
    end
  endtask

  task automatic model_step(input bit ld, input logic [3:0] cc, input bit st,
                            input bit ab, input bit v, input logic [3:0] d);
    for (int k = 0; k < 2; k++) begin
      if (ab) begin
        m_active[k] = 0; m_hitcyc[k] = 0; m_streak[k] = 0;
      end else if (!m_active[k]) begin
        if (ld) m_const[k] = cc;
        if (st) begin m_active[k] = 1; m_streak[k] = 0; m_total[k] = 0; end
      end else if (m_hitcyc[k]) begin
        m_hitcyc[k] = 0;
      end else if (v) begin
        m_eq[k] = (d == m_const[k]);
        if (!m_eq[k]) m_streak[k] = 0;
        else begin
          m_streak[k]++;
          if (m_streak[k] == mc[k]) begin
            m_hitcyc[k] = 1;
            m_streak[k] = 0;
            if (m_total[k] < 255) m_total[k]++;
          end
        end
      end
    end
  endtask

  task automatic check_now(input string name, input int k, input logic [11:0] want);
    logic [11:0] got;
    got = obs(k);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s mc=%0d got {ir,eq,hit,busy,tot}=%03h want=%03h t=%0t",
               name, mc[k], got, want, $time);
    end
  endtask

  task automatic drive(input bit ld, input logic [3:0] cc, input bit st,
                       input bit ab, input bit v, input logic [3:0] d);
    u_if3.cfg_load = ld; u_if3.cfg_const = cc; u_if3.start = st;
    u_if3.abort = ab; u_if3.in_valid = v; u_if3.in_data = d;
    u_if1.cfg_load = ld; u_if1.cfg_const = cc; u_if1.start = st;
    u_if1.abort = ab; u_if1.in_valid = v; u_if1.in_data = d;
  endtask

  // One clock of stimulus; expected post-edge outputs go to the scoreboard
  task automatic cyc(input bit ld, input logic [3:0] cc, input bit st,
                     input bit ab, input bit v, input logic [3:0] d);
    @(negedge clk);
    drive(ld, cc, st, ab, v, d);
    model_step(ld, cc, st, ab, v, d);
    exp_q3.push_back(model_out(0));
    exp_q1.push_back(model_out(1));
  endtask

  task automatic sample(input logic [3:0] d);
    cyc(0, 4'h0, 0, 0, 1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 4'h0, 0, 0, 0, 4'h0);
  endtask

  // Monitor: compares each DUT against the scoreboard after every edge
  initial begin
    logic [11:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q3.size() > 0) begin w = exp_q3.pop_front(); check_now("cycle_chk", 0, w); end
      if (exp_q1.size() > 0) begin w = exp_q1.pop_front(); check_now("cycle_chk", 1, w); end
    end
  end

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    logic [3:0] d;
    bit ld, st, ab, v;
    rst_n = 1'b0;
    drive(0, 4'h0, 0, 0, 0, 4'h0);
    model_reset();
    #1;
    check_now("reset_vals", 0, 12'h000);
    check_now("reset_vals", 1, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // Samples with no start are never consumed
    sample(4'h0); sample(4'h0); sample(4'h0);

    // Load 0101, start, 5,5,5 -> hit; a sample offered during HIT is ignored
    cyc(1, 4'b0101, 0, 0, 0, 4'h0);
    cyc(0, 4'h0, 1, 0, 0, 4'h0);
    sample(4'h5); sample(4'h5); sample(4'h5); sample(4'h5);
    idle(2);

    // 5,5,4,5,5,5: mismatch breaks the streak
    sample(4'h5); sample(4'h5); sample(4'h4);
    sample(4'h5); sample(4'h5); sample(4'h5);
    idle(2);

    // Gaps of in_valid=0 do not break the run
    sample(4'h5); sample(4'h5); idle(3); sample(4'h5);
    idle(2);

    // Abort with start mid-run, then a fresh run
    sample(4'h5); sample(4'h5);
    cyc(0, 4'h0, 1, 1, 1, 4'h5);
    idle(2);
    sample(4'h5);
    cyc(0, 4'h0, 1, 0, 0, 4'h0);
    sample(4'h5); sample(4'h5); sample(4'h5);
    idle(2);

    // cfg_load during RUN is ignored; 5 still matches
    cyc(1, 4'b1111, 0, 0, 1, 4'h5);
    sample(4'hF); sample(4'h5);

    // Saturation: continuous matches give many hits
    for (int i = 0; i < 540; i++) sample(4'h5);
    idle(2);

    // Start during RUN is ignored (hit_total not cleared)
    cyc(0, 4'h0, 1, 0, 1, 4'h5);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      ab = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 7) == 0);
      ld = ($urandom_range(0, 9) == 0);
      v  = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 2) != 0) ? m_const[0] : 4'($urandom_range(0, 15));
      cyc(ld, 4'($urandom_range(0, 15)), st, ab, v, d);
    end
    cyc(0, 4'h0, 1, 0, 0, 4'h0);
    sample(m_const[0]); sample(m_const[0]);

    // Asynchronous reset mid-run, between clock edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", 0, 12'h000);
    check_now("async_reset", 1, 12'h000);
    drive(0, 4'h0, 0, 0, 0, 4'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // After reset: partial run discarded, start required, constant back to 0
    sample(4'h0); sample(4'h0);
    cyc(0, 4'h0, 1, 0, 0, 4'h0);
    sample(4'h0); sample(4'h0); sample(4'h0);
    idle(3);

    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
